// File: rtl/mux_operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: state encodings, default width, counter width.
package mux_operand_sequencer_pkg;
   typedef enum logic [2:0] {
      LOAD_A = 3'd0,
      LOAD_B = 3'd1,
      SHOW_A = 3'd2,
      SHOW_B = 3'd3,
      FINISH = 3'd4
   } seq_state_t;

   localparam int DEF_WIDTH = 4;
   // Four bits cover the full legal HOLD_CYCLES range of 1..15.
   localparam int CNT_W = 4;
endpackage

// File: rtl/mux_operand_sequencer_hold_counter.sv
// Phase-hold counter: counts enabled cycles and flags HOLD_CYCLES-1, wrapping to 0 there.
// Zero latency on the flag (decoded from the count register); no backpressure.
module hold_counter
   import mux_operand_sequencer_pkg::*;
#(
   parameter int HOLD_CYCLES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic en,
   output logic term
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   assign term = (r_cnt == LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (en) begin
         if (term) r_cnt <= '0;
         else      r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mux_operand_sequencer.sv
// Loads operands A then B over a valid/ready bus, then shows A and B on the mux for HOLD_CYCLES each and pulses done.
// Outputs valid the cycle after B is accepted; in_ready is low outside LOAD_A/LOAD_B and nothing is buffered.
module mux_operand_sequencer
   import mux_operand_sequencer_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             sel,
   output logic             out_valid,
   output logic             done
);
   seq_state_t r_state;
   seq_state_t w_next;
   logic       w_xfer;
   logic       w_term;
   logic       w_cnt_en;
   logic       w_cnt_clr;

   assign in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign w_xfer    = in_valid && in_ready && !clear;
   assign w_cnt_en  = (r_state == SHOW_A) || (r_state == SHOW_B);
   assign w_cnt_clr = clear || (w_xfer && (r_state == LOAD_B));

   hold_counter #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold (
      .clk   (clk),
      .resetn(resetn),
      .clear (w_cnt_clr),
      .en    (w_cnt_en),
      .term  (w_term)
   );

   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = LOAD_A;
      end else begin
         case (r_state)
            LOAD_A:  if (w_xfer) w_next = LOAD_B;
            LOAD_B:  if (w_xfer) w_next = SHOW_A;
            SHOW_A:  if (w_term) w_next = SHOW_B;
            SHOW_B:  if (w_term) w_next = FINISH;
            FINISH:  w_next = LOAD_A;
            default: w_next = LOAD_A;
         endcase
      end
   end

   // Moore outputs are registered from the next state so they align with the state they describe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= LOAD_A;
         sel       <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         r_state   <= w_next;
         sel       <= (w_next == SHOW_B);
         out_valid <= (w_next == SHOW_A) || (w_next == SHOW_B);
         done      <= (w_next == FINISH);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a <= '0;
         b <= '0;
      end else if (clear) begin
         a <= '0;
         b <= '0;
      end else if (w_xfer && (r_state == LOAD_A)) begin
         a <= in_data;
      end else if (w_xfer && (r_state == LOAD_B)) begin
         b <= in_data;
      end
   end
endmodule
